// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch front end: IDLE/FETCH/ISSUE over an imem req/ack port.
// Define IFETCH_PERF_CNT_EN to build the retired/redirect performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_W     = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_taken,
  output logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic [5:0]      funct,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     redirect_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic            accept;
  logic            retire;
  logic            pcsrc;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] pc_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = ISSUE;
      ISSUE:   if (instr_taken) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      FETCH:   imem_req = 1'b1;
      ISSUE:   instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = (state == FETCH) & imem_ack;
  assign retire = (state == ISSUE) & instr_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr <= '0;
    end else if (accept) begin
      instr <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (retire) begin
      pc <= pc_nxt;
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign pc_plus4  = pc + PC_W'(4);

  assign pcsrc   = branch & zero;
  assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_tgt  = pc_plus4 + br_off;
  assign jmp_tgt = {pc_plus4[PC_W-1:PC_W-4], instr[25:0], 2'b00};

  // jump wins over a taken branch when both are asserted
  always_comb begin
    pc_nxt = pc_plus4;
    priority case (1'b1)
      jump:    pc_nxt = jmp_tgt;
      pcsrc:   pc_nxt = br_tgt;
      default: pc_nxt = pc_plus4;
    endcase
  end

`ifdef IFETCH_PERF_CNT_EN
  logic redirect;

  assign redirect = jump | pcsrc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt  <= '0;
      redirect_cnt <= '0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (redirect) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`else
  assign retired_cnt  = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: three instances with different RESET_PC,
// table vectors, hand sequences and a randomized run against a PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'h4000_0020;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic clk;
  logic reset_n;

  logic        ack   [3];
  logic        taken [3];
  logic        br    [3];
  logic        zr    [3];
  logic        jp    [3];
  logic [31:0] rdata [3];

  wire        req  [3];
  wire        vld  [3];
  wire [31:0] addr [3];
  wire [31:0] ins  [3];
  wire [31:0] pcv  [3];
  wire [31:0] pc4  [3];
  wire [31:0] rcnt [3];
  wire [31:0] dcnt [3];
  wire [5:0]  opc  [3];
  wire [5:0]  fun  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_fetch_unit #(
      .RESET_PC(g == 0 ? RPC0 : (g == 1 ? RPC1 : RPC2)),
      .PC_W(32)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .imem_req(req[g]),
      .imem_addr(addr[g]),
      .imem_ack(ack[g]),
      .imem_rdata(rdata[g]),
      .instr_valid(vld[g]),
      .instr_taken(taken[g]),
      .instr(ins[g]),
      .opcode(opc[g]),
      .funct(fun[g]),
      .pc(pcv[g]),
      .pc_plus4(pc4[g]),
      .branch(br[g]),
      .zero(zr[g]),
      .jump(jp[g]),
      .retired_cnt(rcnt[g]),
      .redirect_cnt(dcnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nerr;
  int m_ret;
  int m_red;
  logic [31:0] epc [3];

  typedef struct {
    logic [31:0] d;
    int          wt;
    int          hold;
    bit          spur;
    logic        b;
    logic        z;
    logic        j;
    logic [31:0] nxt;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [31:0] rpc(input int u);
    return u == 0 ? RPC0 : (u == 1 ? RPC1 : RPC2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_next(
    input logic [31:0] p, input logic [31:0] d,
    input logic b, input logic z, input logic j);
    logic [31:0] p4;
    logic [15:0] imm;
    int off;
    p4 = p + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((d & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      imm = d[15:0];
      off = $signed(imm);
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input int u, input logic [31:0] d, input int wt);
    for (int i = 0; i < wt; i++) begin
      chk("req_wait", req[u], 1);
      chk("addr_wait", addr[u], epc[u]);
      chk("valid_wait", vld[u], 0);
      cyc();
    end
    chk("req", req[u], 1);
    chk("addr", addr[u], epc[u]);
    ack[u] = 1'b1;
    rdata[u] = d;
    cyc();
    ack[u] = 1'b0;
    rdata[u] = $urandom;
    chk("valid", vld[u], 1);
    chk("req_issue", req[u], 0);
    chk("instr", ins[u], d);
    chk("opcode", opc[u], d >> 26);
    chk("funct", fun[u], d & 32'h3F);
    chk("pc", pcv[u], epc[u]);
    chk("pc_plus4", pc4[u], epc[u] + 32'd4);
  endtask

  task automatic issue_one(input int u, input logic [31:0] d,
                           input int hold, input bit spur,
                           input logic b, input logic z, input logic j,
                           input logic [31:0] nxt);
    for (int i = 0; i < hold; i++) begin
      br[u] = 1'($urandom);
      zr[u] = 1'($urandom);
      jp[u] = 1'($urandom);
      if (spur && i == 0) begin
        ack[u] = 1'b1;
        rdata[u] = ~d;
      end
      cyc();
      ack[u] = 1'b0;
      chk("valid_hold", vld[u], 1);
      chk("instr_hold", ins[u], d);
      chk("req_hold", req[u], 0);
      chk("pc_hold", pcv[u], epc[u]);
    end
    taken[u] = 1'b1;
    br[u] = b;
    zr[u] = z;
    jp[u] = j;
    cyc();
    taken[u] = 1'b0;
    br[u] = 1'($urandom);
    zr[u] = 1'($urandom);
    jp[u] = 1'($urandom);
    if (u == 0) begin
      m_ret++;
      if (j || (b && z)) m_red++;
    end
    epc[u] = nxt;
    chk("req_next", req[u], 1);
    chk("addr_next", addr[u], nxt);
    chk("valid_next", vld[u], 0);
  endtask

  task automatic run_one(input int u, input logic [31:0] d, input int wt,
                         input int hold, input bit spur, input logic b,
                         input logic z, input logic j,
                         input logic [31:0] nxt);
    fetch_one(u, d, wt);
    issue_one(u, d, hold, spur, b, z, j, nxt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic b, z, j;
    int wt, hold;
    bit spur;

    nvec = 0;
    nerr = 0;
    m_ret = 0;
    m_red = 0;

    tbl[0] = '{32'h2008_0005, 1, 0, 0, 0, 0, 0, 32'h0000_0004};
    tbl[1] = '{32'h2008_0005, 1, 0, 0, 0, 0, 0, 32'h0000_0008};
    tbl[2] = '{32'h2008_0005, 1, 0, 0, 0, 0, 0, 32'h0000_000C};
    tbl[3] = '{32'h2008_0005, 0, 1, 0, 0, 0, 0, 32'h0000_0010};
    tbl[4] = '{32'h1000_FFFE, 1, 0, 0, 1, 1, 0, 32'h0000_000C};
    tbl[5] = '{32'h2008_0005, 0, 0, 0, 0, 0, 0, 32'h0000_0010};
    tbl[6] = '{32'h1000_FFFE, 1, 0, 0, 1, 0, 0, 32'h0000_0014};
    tbl[7] = '{32'h0800_0100, 2, 1, 0, 1, 1, 1, 32'h0000_0400};
    tbl[8] = '{32'hDEAD_BEEF, 5, 3, 1, 0, 0, 0, 32'h0000_0404};

    for (int u = 0; u < 3; u++) begin
      ack[u] = 0;
      taken[u] = 0;
      br[u] = 0;
      zr[u] = 0;
      jp[u] = 0;
      rdata[u] = 0;
      epc[u] = rpc(u);
    end

    reset_n = 1'b0;
    cyc();
    cyc();
    for (int u = 0; u < 3; u++) begin
      chk("rst_req", req[u], 0);
      chk("rst_valid", vld[u], 0);
      chk("rst_pc", pcv[u], rpc(u));
      chk("rst_instr", ins[u], 0);
      chk("rst_retired", rcnt[u], 0);
      chk("rst_redirect", dcnt[u], 0);
    end

    reset_n = 1'b1;
    for (int u = 0; u < 3; u++) chk("idle_req", req[u], 0);
    cyc();
    for (int u = 0; u < 3; u++) begin
      chk("first_req", req[u], 1);
      chk("first_addr", addr[u], rpc(u));
    end

    run_one(2, 32'h2008_0005, 1, 0, 0, 0, 0, 0, 32'h0000_0000);
    run_one(1, 32'h0800_0100, 1, 0, 0, 1, 1, 1, 32'h4000_0400);

    for (int k = 0; k < 9; k++) begin
      run_one(0, tbl[k].d, tbl[k].wt, tbl[k].hold, tbl[k].spur,
              tbl[k].b, tbl[k].z, tbl[k].j, tbl[k].nxt);
    end

    ack[0] = 1'b1;
    rdata[0] = 32'hCAFE_F00D;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_req", req[0], 0);
    chk("midrst_valid", vld[0], 0);
    chk("midrst_pc", pcv[0], RPC0);
    ack[0] = 1'b0;
    cyc();
    cyc();
    chk("midrst_instr", ins[0], 0);
    chk("midrst_retired", rcnt[0], 0);
    chk("midrst_redirect", dcnt[0], 0);
    reset_n = 1'b1;
    chk("midrst_idle_req", req[0], 0);
    cyc();
    for (int u = 0; u < 3; u++) epc[u] = rpc(u);
    chk("midrst_refetch", addr[0], RPC0);
    m_ret = 0;
    m_red = 0;

    run_one(0, 32'h2008_0005, 0, 0, 0, 0, 0, 0, 32'h0000_0004);
    run_one(0, 32'h0800_0010, 1, 0, 0, 0, 0, 1, 32'h0000_0040);
    run_one(0, 32'h1000_0003, 0, 1, 0, 1, 1, 0, 32'h0000_0050);
    run_one(0, 32'h1000_0003, 2, 0, 0, 1, 0, 0, 32'h0000_0054);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_retired", rcnt[0], 4);
    chk("perf_redirect", dcnt[0], 2);
`else
    chk("perf_retired_off", rcnt[0], 0);
    chk("perf_redirect_off", dcnt[0], 0);
`endif

    for (int n = 0; n < 200; n++) begin
      d = $urandom;
      wt = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      spur = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 3) == 0);
      b = 1'($urandom);
      z = 1'($urandom);
      run_one(0, d, wt, hold, spur, b, z, j,
              model_next(epc[0], d, b, z, j));
    end
`ifdef IFETCH_PERF_CNT_EN
    chk("rand_retired", rcnt[0], 32'(m_ret));
    chk("rand_redirect", dcnt[0], 32'(m_red));
`else
    chk("rand_retired_off", rcnt[0], 0);
    chk("rand_redirect_off", dcnt[0], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential front end of the MIPS datapath. Produces the instruction fields consumed by the control unit: opcode, funct and the full instruction word.
- Consumes the control unit's branch/zero/jump outputs to choose the next PC.
- Fetches from instruction memory using a req/ack handshake.
- Holds each instruction stable until the execute side accepts it.
- Computes the branch condition pcsrc = branch & zero internally.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 00).
- PC_W, 32, PC and address width (fixed to 32 for this core).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  word-aligned fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory response valid, single-cycle pulse.
- imem_rdata  in  32  instruction word; sampled only when imem_ack=1.
- instr_valid  out  1  instr/opcode/funct/pc outputs are valid.
- instr_taken  in  1  execute side has consumed the current instruction.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4.
- branch  in  1  control Branch; qualified by instr_valid & instr_taken.
- zero  in  1  ALU zero flag for the current instruction.
- jump  in  1  control jump.
- retired_cnt  out  32  performance counter (see Optional Feature).
- redirect_cnt  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State IDLE, pc=RESET_PC, instr=0.
  - imem_req=0, instr_valid=0, counters=0.
  - Takes effect immediately, including mid-fetch or mid-issue. Any pending request is abandoned.
- FSM states: IDLE, FETCH, ISSUE.
- IDLE:
  - Outputs imem_req=0 and instr_valid=0.
  - Unconditionally moves to FETCH on the next clk edge. This is the first cycle after reset_n rises.
- FETCH:
  - Drives imem_req=1 and imem_addr=pc. Both are held stable until imem_ack.
  - On an edge with imem_ack=1: instr <= imem_rdata and the state moves to ISSUE.
  - imem_ack in the same cycle as the first imem_req is legal (zero-wait memory).
- ISSUE:
  - Drives instr_valid=1 and imem_req=0. instr, opcode, funct, pc and pc_plus4 are stable.
  - Stays in ISSUE while instr_taken=0.
  - On an edge with instr_taken=1, pc is loaded with the next PC and the state moves to FETCH.
- Latency:
  - imem_ack edge to instr_valid=1: 1 cycle.
  - instr_taken edge to imem_req=1 at the new pc: 1 cycle.
- imem_ack outside FETCH is ignored; instr is not updated.
- Next-PC priority is jump > (branch & zero) > sequential:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch=1 and zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - otherwise: pc_plus4.
- Arithmetic:
  - All sums are 32-bit modulo 2^32, so pc 32'hFFFF_FFFC + 4 wraps to 0.
  - Negative branch offsets wrap the same way.
  - pc[1:0] is always 00.
- branch, zero and jump are sampled only on the instr_taken edge; their values at other times are don't-care.
- opcode, funct and pc_plus4 are combinational from the registers; they are defined but meaningless when instr_valid=0.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined:
  - retired_cnt increments by 1 on every ISSUE edge with instr_taken=1.
  - redirect_cnt increments on those edges when jump | (branch & zero).
  - Both wrap at 2^32 and clear on reset.
- Undefined:
  - Both ports are tied to 0 and no counter flops are synthesised.
- Fetch behaviour is identical either way.

Test Plan:
- Reset and sequential fetch, RESET_PC=0: release reset_n; ack each request 1 cycle after req with rdata=32'h2008_0005; pulse instr_taken each issue. Required:
  - imem_req is low in the first cycle after release.
  - imem_addr sequence is 0, 4, 8.
  - opcode=6'h08 and instr_valid rises 1 cycle after each ack.
- Taken branch, pc=32'h0000_0010: instr=32'h1000_FFFE; instr_taken with branch=1, zero=1. Required: next imem_addr=32'h0000_000C. Same stimulus with zero=0: next imem_addr=32'h0000_0014.
- Jump priority, pc=32'h4000_0020: instr=32'h0800_0100; instr_taken with jump=1 and branch=1, zero=1. Required: next imem_addr=32'h4000_0400.
- Wait-state memory: delay imem_ack by 5 cycles, then hold instr_taken=0 for 3 cycles in ISSUE. Required:
  - imem_addr and imem_req are stable throughout the wait.
  - instr is stable and instr_valid=1 throughout the hold.
  - A spurious ack during ISSUE does not change instr.
- Reset mid-operation and wrap-around:
  - Assert reset_n=0 while in FETCH with an ack pending. Required: imem_req=0 and instr_valid=0 immediately, and pc=RESET_PC.
  - With RESET_PC=32'hFFFF_FFFC, one sequential instruction. Required: next imem_addr=32'h0000_0000.
- IFETCH_PERF_CNT_EN defined: issue 4 instructions containing 1 jump and 1 branch with zero=1. Required: retired_cnt=4 and redirect_cnt=2. With the macro undefined, both read 0.
